pcs_loopback_buf: RTL and testbench
===================================

# pcs_loopback_buf

Elastic buffer between the PCS receive path and the PCS transmit path in the RX→TX loopback. It absorbs the transmit gearbox's periodic `ready` deassertions and the receive path's invalid cycles. Rate matching is done only in inter-frame gaps: idle blocks are deleted when the buffer runs high and inserted when it runs empty. Frames pass through unmodified; anomalies are flagged rather than silently corrupting data.

## Interface
- `IS_10G`, 1: selects start-lane width, `LANE0_CNT_N = IS_10G ? 2 : 1`.
- `DATA_W`, 64: block payload width.
- `KEEP_W`, `DATA_W/8`: byte-keep width.
- `DEPTH`, 16: number of FIFO entries; must be a power of 2, ≥ 8.
- `HI_WM`, 12: fill level at or above which incoming gap idles are deleted.
- `clk` in 1: single clock (logic clock); all signals are synchronous to it.
- `reset` in 1: synchronous, active-high reset.
- `valid_i` in 1: the input block is meaningful; when low, the block is ignored.
- `ctrl_v_i`, `idle_v_i`, `term_v_i`, `err_v_i` in 1 each: control flags from the PCS RX.
- `start_v_i` in `LANE0_CNT_N`: start-of-frame lane flags.
- `data_i` in `DATA_W`, `keep_i` in `KEEP_W`: payload and byte keep.
- `ready_i` in 1: the PCS TX consumes the output block this cycle.
- `ctrl_v_o`, `idle_v_o`, `term_v_o`, `err_v_o` out 1 each; `start_v_o` out `LANE0_CNT_N`; `data_o` out `DATA_W`; `keep_o` out `KEEP_W`: block presented to the PCS TX.
- `fill_o` out `$clog2(DEPTH)+1`: current FIFO occupancy.
- `idle_del_o`, `idle_ins_o`, `overflow_o`, `underrun_o` out 1 each: single-cycle event pulses.

## Operation
- Entry format: {ctrl, idle, term, err, start, keep, data}.
- Input classification:
  - A gap idle has `valid_i & ctrl_v_i & idle_v_i` and no start, term or err flag set.
  - Every other block with `valid_i=1` is a frame-relevant block.
- Write rules:
  - `valid_i=0`: no write.
  - Gap idle with `fill ≥ HI_WM`: dropped; `idle_del_o=1`.
  - Otherwise, if not full: pushed.
  - Otherwise (full): dropped; `overflow_o=1`.
  - After an overflow drop, the next pushed entry has its `err` flag forced to 1. This marks the corrupted frame downstream.
- The output state machine has two states, GAP and FRAME; it resets to GAP.
- Output transitions occur only on a cycle where `ready_i=1`:
  - FIFO non-empty: pop the head entry and load it into the output register.
    - In GAP, a popped entry with start≠0 moves the state to FRAME.
    - In FRAME, a popped entry with `term` or `err` set moves the state to GAP.
  - FIFO empty in GAP: load the IDLE block; `idle_ins_o=1`.
  - FIFO empty in FRAME: load the ERROR block; `underrun_o=1`; state → GAP.
- IDLE block: ctrl=1, idle=1, all other flags 0, keep=0, data=0.
- ERROR block: ctrl=1, err=1, all other flags 0, keep=0, data=0.
- With `ready_i=0`, the output register and the state are held.
- Push and pop in the same cycle are both performed, and fill is unchanged.
- `fill_o` saturates at neither end: by construction it stays in the range 0..DEPTH.

## Timing
- Reset (synchronous, one cycle):
  - Output register = IDLE block.
  - State = GAP; fill = 0; read and write pointers = 0.
  - All pulse outputs = 0.
  - The overflow-err pending flag is cleared.
- Output is registered. A block written at edge t is at the FIFO head at t+1. The earliest it can appear on the outputs is after edge t+1, and only if `ready_i=1` in cycle t+1. There is no bypass of the empty FIFO.
- Consumption: the block present in cycle t is taken by the PCS TX iff `ready_i=1` in cycle t. The next block is visible in cycle t+1.
- Event pulses are asserted combinationally in the cycle the event occurs and last exactly one cycle.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. The full/empty test uses the fill counter.
- When reset is asserted mid-frame, the in-flight contents are discarded and no ERROR block is emitted. The first output after reset is IDLE.

## Structure
- Shared package `pcs_loopback_pkg` holds:
  - the entry struct `lb_entry_t`;
  - the constants `LB_IDLE_BLK` and `LB_ERR_BLK`;
  - the `LANE0_CNT_N` derivation.
- One sub-module, `lb_sync_fifo`: a parameterized single-clock FIFO with synchronous reset, exposing push, pop, head data, full, empty and fill. Classification, the state machine, and idle insertion/deletion live in the top `pcs_loopback_buf`.

## Test plan
- Straight-through: a continuous 8-block frame (start, 6 data, term) with `ready_i` held at 1. Required: the identical 8 blocks appear on the outputs one cycle after reaching the FIFO head, and no event pulses occur.
- Gearbox stall: drive `ready_i` low for 1 cycle in every 32 during a 64-block frame with gap idles between frames. Required: all frame blocks are emitted in order with no drop, `underrun_o` and `overflow_o` stay 0, and `idle_del_o` pulses only on gap idles.
- High watermark: hold `ready_i=0` until fill = 12, then feed gap idles. Required: each such idle raises `idle_del_o` and fill stays at 12. A start block arriving at fill 12 is pushed, making fill 13.
- Underrun: a frame with start followed by `valid_i=0` for 4 cycles while `ready_i=1`. Required: after the start block is output, the next output block is the ERROR block (ctrl=1, err=1), `underrun_o=1` for one cycle, the state returns to GAP, and IDLE blocks follow.
- Overflow: hold `ready_i=0` and push 17 non-idle blocks. Required: fill = 16, `overflow_o=1` on the 17th block. The next pushed block has err=1 when it is eventually popped.
- Reset mid-frame: assert `reset` with fill = 5 in state FRAME. Required: the cycle after reset shows an IDLE output, `fill_o=0` and no pulses.

Source files
------------

// File: rtl/pcs_loopback_buf_pkg.sv
// Shared types and constants for the PCS RX->TX loopback elastic buffer.
package pcs_loopback_pkg;

  // Start-lane flag count: 10G carries two possible start lanes, otherwise one.
  function automatic int unsigned lane0_cnt_n(input bit is_10g);
    return is_10g ? 2 : 1;
  endfunction

  localparam bit          LB_IS_10G   = 1'b1;
  localparam int unsigned LANE0_CNT_N = lane0_cnt_n(LB_IS_10G);
  localparam int unsigned LB_DATA_W   = 64;
  localparam int unsigned LB_KEEP_W   = LB_DATA_W / 8;

  // One buffered block: {ctrl, idle, term, err, start, keep, data}.
  typedef struct packed {
    logic                   ctrl;
    logic                   idle;
    logic                   term;
    logic                   err;
    logic [LANE0_CNT_N-1:0] start;
    logic [LB_KEEP_W-1:0]   keep;
    logic [LB_DATA_W-1:0]   data;
  } lb_entry_t;

  localparam lb_entry_t LB_IDLE_BLK = '{ctrl: 1'b1, idle: 1'b1, term: 1'b0, err: 1'b0,
                                        start: '0, keep: '0, data: '0};
  localparam lb_entry_t LB_ERR_BLK  = '{ctrl: 1'b1, idle: 1'b0, term: 1'b0, err: 1'b1,
                                        start: '0, keep: '0, data: '0};

endpackage

// File: rtl/pcs_loopback_buf_if.sv
// Block bus between PCS RX, the loopback buffer and PCS TX.
interface pcs_loopback_buf_if #(
  parameter int unsigned LANE_N = 2,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = DATA_W / 8
);
  // RX side
  logic              valid_i;
  logic              ctrl_v_i;
  logic              idle_v_i;
  logic              term_v_i;
  logic              err_v_i;
  logic [LANE_N-1:0] start_v_i;
  logic [DATA_W-1:0] data_i;
  logic [KEEP_W-1:0] keep_i;
  // TX side
  logic              ready_i;
  logic              ctrl_v_o;
  logic              idle_v_o;
  logic              term_v_o;
  logic              err_v_o;
  logic [LANE_N-1:0] start_v_o;
  logic [DATA_W-1:0] data_o;
  logic [KEEP_W-1:0] keep_o;

  modport master (
    output valid_i, ctrl_v_i, idle_v_i, term_v_i, err_v_i, start_v_i, data_i, keep_i, ready_i,
    input  ctrl_v_o, idle_v_o, term_v_o, err_v_o, start_v_o, data_o, keep_o
  );

  modport slave (
    input  valid_i, ctrl_v_i, idle_v_i, term_v_i, err_v_i, start_v_i, data_i, keep_i, ready_i,
    output ctrl_v_o, idle_v_o, term_v_o, err_v_o, start_v_o, data_o, keep_o
  );
endinterface

// File: rtl/pcs_loopback_buf_fifo.sv
// Single-clock FIFO; full/empty derived from the fill counter.
module lb_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_din,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_fill
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_fill;
  logic             w_push;
  logic             w_pop;

  // Qualify requests against current occupancy
  always_comb begin
    o_full  = (r_fill == FULL_LVL);
    o_empty = (r_fill == '0);
    w_push  = i_push & ~o_full;
    w_pop   = i_pop & ~o_empty;
    o_head  = r_mem[r_rptr];
    o_fill  = r_fill;
  end

  // Storage array (contents need no reset)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // Pointers wrap modulo DEPTH; fill tracks push/pop balance
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end
endmodule

// File: rtl/pcs_loopback_buf.sv
// RX->TX loopback elastic buffer: deletes gap idles when running high,
// inserts IDLE when empty between frames, ERROR on mid-frame underrun.
module pcs_loopback_buf
  import pcs_loopback_pkg::*;
#(
  parameter bit          IS_10G = 1'b1,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned HI_WM  = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  pcs_loopback_buf_if.slave      lb,
  output logic [$clog2(DEPTH):0] fill_o,
  output logic                   idle_del_o,
  output logic                   idle_ins_o,
  output logic                   overflow_o,
  output logic                   underrun_o
);
  localparam int unsigned LANE_N  = lane0_cnt_n(IS_10G);
  // Entry layout follows lb_entry_t, so widths must match the package configuration
  localparam int unsigned ENTRY_W = 4 + LANE_N + KEEP_W + DATA_W;
  localparam int unsigned FW      = $clog2(DEPTH) + 1;

  typedef enum logic {ST_GAP, ST_FRAME} state_t;

  state_t           r_state;
  lb_entry_t        r_out;
  logic             r_ovf_pend;

  lb_entry_t        w_wr_entry;
  lb_entry_t        w_head;
  logic [ENTRY_W-1:0] w_head_vec;
  logic             w_full;
  logic             w_empty;
  logic [FW-1:0]    w_fill;
  logic             w_gap_idle;
  logic             w_del;
  logic             w_push;
  logic             w_ovf;
  logic             w_pop;

  lb_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_wr_entry),
    .o_head  (w_head_vec),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_fill  (w_fill)
  );

  // Classify the incoming block and decide push / delete / overflow
  always_comb begin
    w_head     = lb_entry_t'(w_head_vec);
    w_gap_idle = lb.valid_i & lb.ctrl_v_i & lb.idle_v_i &
                 ~(|lb.start_v_i) & ~lb.term_v_i & ~lb.err_v_i;
    w_del      = w_gap_idle & (w_fill >= FW'(HI_WM));
    w_push     = lb.valid_i & ~w_del & ~w_full & ~reset;
    w_ovf      = lb.valid_i & ~w_del & w_full & ~reset;
    w_pop      = lb.ready_i & ~w_empty & ~reset;
    w_wr_entry = '{ctrl: lb.ctrl_v_i, idle: lb.idle_v_i, term: lb.term_v_i,
                   err: lb.err_v_i | r_ovf_pend, start: lb.start_v_i,
                   keep: lb.keep_i, data: lb.data_i};
  end

  // Event pulses for the current cycle
  always_comb begin
    idle_del_o = w_del & ~reset;
    overflow_o = w_ovf;
    idle_ins_o = lb.ready_i & w_empty & (r_state == ST_GAP) & ~reset;
    underrun_o = lb.ready_i & w_empty & (r_state == ST_FRAME) & ~reset;
    fill_o     = w_fill;
  end

  // Remember an overflow drop so the next stored block carries err
  always_ff @(posedge clk) begin
    if (reset)       r_ovf_pend <= 1'b0;
    else if (w_ovf)  r_ovf_pend <= 1'b1;
    else if (w_push) r_ovf_pend <= 1'b0;
  end

  // GAP/FRAME tracker and registered output block
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_GAP;
      r_out   <= LB_IDLE_BLK;
    end else if (lb.ready_i) begin
      if (!w_empty) begin
        r_out <= w_head;
        if (r_state == ST_GAP && (|w_head.start))
          r_state <= ST_FRAME;
        else if (r_state == ST_FRAME && (w_head.term || w_head.err))
          r_state <= ST_GAP;
      end else if (r_state == ST_GAP) begin
        r_out <= LB_IDLE_BLK;
      end else begin
        r_out   <= LB_ERR_BLK;
        r_state <= ST_GAP;
      end
    end
  end

  // Drive the TX-side block from the output register
  always_comb begin
    lb.ctrl_v_o  = r_out.ctrl;
    lb.idle_v_o  = r_out.idle;
    lb.term_v_o  = r_out.term;
    lb.err_v_o   = r_out.err;
    lb.start_v_o = r_out.start;
    lb.keep_o    = r_out.keep;
    lb.data_o    = r_out.data;
  end
endmodule

// File: tb/tb_pcs_loopback_buf.sv
// Scoreboard bench for pcs_loopback_buf: directed scenarios plus random traffic.
module tb_pcs_loopback_buf;
  localparam int unsigned LN = 2, DW = 64, KW = 8, DEPTH = 16, HI_WM = 12;

  typedef struct packed {
    logic ctrl, idle, term, err;
    logic [LN-1:0] start;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } blk_t;

  typedef struct packed {
    logic chk;
    logic [3:0] pulses;   // {del, ins, ovf, und}
    logic [4:0] fill;
  } cyc_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] fill_o;
  logic idle_del_o, idle_ins_o, overflow_o, underrun_o;

  always #5 clk = ~clk;

  pcs_loopback_buf_if #(.LANE_N(LN), .DATA_W(DW), .KEEP_W(KW)) lb ();

  pcs_loopback_buf #(
    .IS_10G (1'b1),
    .DATA_W (DW),
    .KEEP_W (KW),
    .DEPTH  (DEPTH),
    .HI_WM  (HI_WM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .lb         (lb),
    .fill_o     (fill_o),
    .idle_del_o (idle_del_o),
    .idle_ins_o (idle_ins_o),
    .overflow_o (overflow_o),
    .underrun_o (underrun_o)
  );

  blk_t mq[$];     // reference FIFO contents
  blk_t outq[$];   // expected output blocks, in load order
  cyc_t cycq[$];   // expected per-cycle pulses and fill
  int   tests = 0;
  int   fails = 0;
  bit   in_frame = 1'b0;
  bit   pend = 1'b0;
  bit   started = 1'b0;

  function automatic blk_t idle_blk();
    blk_t b = '0;
    b.ctrl = 1'b1; b.idle = 1'b1;
    return b;
  endfunction

  function automatic blk_t err_blk();
    blk_t b = '0;
    b.ctrl = 1'b1; b.err = 1'b1;
    return b;
  endfunction

  // 0 gap idle, 1 start, 2 data, 3 term, 4 err
  function automatic blk_t mk(input int k);
    blk_t b;
    b.ctrl = 1'b0; b.idle = 1'b0; b.term = 1'b0; b.err = 1'b0; b.start = '0;
    b.data = {$urandom, $urandom};
    b.keep = KW'($urandom);
    case (k)
      0: b = idle_blk();
      1: begin b.ctrl = 1'b1; b.start = LN'($urandom_range(1, 3)); end
      3: begin b.ctrl = 1'b1; b.term = 1'b1; end
      4: begin b.ctrl = 1'b1; b.err = 1'b1; end
      default: ;
    endcase
    return b;
  endfunction

  function automatic blk_t cur_in();
    blk_t b;
    b.ctrl = lb.ctrl_v_i; b.idle = lb.idle_v_i; b.term = lb.term_v_i; b.err = lb.err_v_i;
    b.start = lb.start_v_i; b.keep = lb.keep_i; b.data = lb.data_i;
    return b;
  endfunction

  task automatic drive(input blk_t b, input bit v, input bit r);
    lb.valid_i = v; lb.ready_i = r;
    lb.ctrl_v_i = b.ctrl; lb.idle_v_i = b.idle; lb.term_v_i = b.term; lb.err_v_i = b.err;
    lb.start_v_i = b.start; lb.keep_i = b.keep; lb.data_i = b.data;
    @(posedge clk);
    #1;
  endtask

  // Reference model: evaluates each cycle's inputs against queue occupancy
  always @(negedge clk) begin
    cyc_t c;
    blk_t e;
    int   n;
    bit   gap, del;
    n = mq.size();
    c = '0;
    c.chk = started;
    c.fill = 5'(n);
    if (reset) begin
      mq.delete();
      in_frame = 1'b0;
      pend = 1'b0;
      outq.push_back(idle_blk());
      started = 1'b1;
    end else begin
      gap = lb.valid_i && lb.ctrl_v_i && lb.idle_v_i && lb.start_v_i == '0 &&
            !lb.term_v_i && !lb.err_v_i;
      del = gap && n >= HI_WM;
      c.pulses[3] = del;
      if (lb.ready_i) begin
        if (n > 0) begin
          e = mq.pop_front();
          if (!in_frame) begin
            if (e.start != '0) in_frame = 1'b1;
          end else if (e.term || e.err) begin
            in_frame = 1'b0;
          end
          outq.push_back(e);
        end else if (!in_frame) begin
          c.pulses[2] = 1'b1;
          outq.push_back(idle_blk());
        end else begin
          c.pulses[0] = 1'b1;
          in_frame = 1'b0;
          outq.push_back(err_blk());
        end
      end
      if (lb.valid_i && !del) begin
        if (n < DEPTH) begin
          e = cur_in();
          e.err = e.err | pend;
          pend = 1'b0;
          mq.push_back(e);
        end else begin
          c.pulses[1] = 1'b1;
          pend = 1'b1;
        end
      end
    end
    cycq.push_back(c);
  end

  // Monitor: compares DUT outputs with the scoreboard queues
  bit   prev_load = 1'b0;
  bit   have_cur = 1'b0;
  blk_t cur_exp;
  always @(negedge clk) begin
    cyc_t c;
    blk_t act;
    logic [3:0] ap;
    #1;
    if (prev_load) begin
      tests++;
      if (outq.size() == 0) begin
        fails++;
        $display("FAIL outq_empty: got none, need a queued expected block");
      end else begin
        cur_exp = outq.pop_front();
        have_cur = 1'b1;
      end
    end
    if (cycq.size() > 0) begin
      c = cycq.pop_front();
      if (c.chk) begin
        ap = {idle_del_o, idle_ins_o, overflow_o, underrun_o};
        tests++;
        if (ap !== c.pulses) begin
          fails++;
          $display("FAIL pulses t=%0t: got del/ins/ovf/und=%b need %b", $time, ap, c.pulses);
        end
        tests++;
        if (fill_o !== c.fill) begin
          fails++;
          $display("FAIL fill t=%0t: got %0d need %0d", $time, fill_o, c.fill);
        end
      end
    end
    if (have_cur) begin
      act.ctrl = lb.ctrl_v_o; act.idle = lb.idle_v_o; act.term = lb.term_v_o; act.err = lb.err_v_o;
      act.start = lb.start_v_o; act.keep = lb.keep_o; act.data = lb.data_o;
      tests++;
      if (act !== cur_exp) begin
        fails++;
        $display("FAIL out_blk t=%0t: got %h need %h", $time, act, cur_exp);
      end
    end
    prev_load = reset || lb.ready_i;
  end

  initial begin
    blk_t z;
    z = '0;
    reset = 1'b1;
    lb.valid_i = 1'b0; lb.ready_i = 1'b0;
    lb.ctrl_v_i = 1'b0; lb.idle_v_i = 1'b0; lb.term_v_i = 1'b0; lb.err_v_i = 1'b0;
    lb.start_v_i = '0; lb.keep_i = '0; lb.data_i = '0;
    drive(z, 0, 0);
    drive(z, 0, 0);
    reset = 1'b0;

    // straight-through 8-block frame
    drive(mk(1), 1, 1);
    repeat (6) drive(mk(2), 1, 1);
    drive(mk(3), 1, 1);
    repeat (4) drive(mk(0), 1, 1);

    // underrun: start then nothing
    drive(mk(1), 1, 1);
    repeat (4) drive(z, 0, 1);
    repeat (3) drive(mk(0), 1, 1);

    // high watermark: fill to 12, gap idles deleted, start still pushed
    drive(mk(1), 1, 0);
    repeat (11) drive(mk(2), 1, 0);
    repeat (3) drive(mk(0), 1, 0);
    drive(mk(1), 1, 0);
    repeat (18) drive(z, 0, 1);

    // overflow: 17 blocks into 16 entries, next stored block carries err
    drive(mk(1), 1, 0);
    repeat (16) drive(mk(2), 1, 0);
    drive(z, 0, 1);
    drive(mk(3), 1, 1);
    repeat (20) drive(z, 0, 1);

    // gearbox stall: ready low 1 in 32, two 64-block frames with gaps
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 64; i++)
        drive(mk(i == 0 ? 1 : (i == 63 ? 3 : 2)), 1, ((i + f * 70) % 32) != 31);
      for (int i = 0; i < 6; i++)
        drive(mk(0), 1, ((64 + i + f * 70) % 32) != 31);
    end
    repeat (20) drive(z, 0, 1);

    // reset mid-frame with 5 entries queued
    drive(mk(1), 1, 1);
    drive(mk(2), 1, 1);
    repeat (4) drive(mk(2), 1, 0);
    reset = 1'b1;
    drive(z, 0, 0);
    reset = 1'b0;
    drive(z, 0, 0);
    drive(z, 0, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = $urandom_range(0, 9);
      drive(mk(k < 3 ? 0 : (k == 3 ? 1 : (k == 4 ? 3 : (k == 5 ? 4 : 2)))),
            $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8);
    end
    repeat (25) drive(z, 0, 1);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
